// File: rtl/rv_pkg.sv
// Shared definitions for the RV32 pipeline.
// Fetch state encoding, reset PC and the canonical NOP.
package rv_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_pc_gen.sv
// Program counter register and next-PC selection (hold / +4 / redirect).
// FETCH_ALIGN_CHECK_EN keeps the raw target and flags misalignment.
module fetch_pc_gen
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        advance,
    input  logic [31:0] target,
    output logic [31:0] pc,
    output logic        misaligned
);

    logic [31:0] target_eff;
    logic [31:0] pc_next;

`ifdef FETCH_ALIGN_CHECK_EN
    assign target_eff = target;
    assign misaligned = target[1:0] != 2'b00;
`else
    assign target_eff = target & 32'hFFFF_FFFC;
    assign misaligned = 1'b0;
`endif

    // Redirect wins over sequential advance.
    always_comb begin
        pc_next = pc;
        if (load) begin
            pc_next = target_eff;
        end else if (advance) begin
            pc_next = pc_inc(pc);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: FSM plus IF/ID register with valid/ready handshake.
// Optional misaligned-redirect trap via FETCH_ALIGN_CHECK_EN.
module fetch_stage
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rd,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic        fetch_fault
);

    logic [1:0]  state;
    logic [31:0] pc;
    logic        misaligned;
    logic        adv;
    logic        pc_load;
    logic        pc_adv;
    logic        fault_q;

    assign adv     = !id_valid || id_ready;
    assign pc_load = redirect_valid && (state != ST_FAULT);
    assign pc_adv  = (state == ST_RUN) && adv && !redirect_valid;

    fetch_pc_gen #(
        .RESET_PC(RESET_PC)
    ) u_pc_gen (
        .clk       (clk),
        .reset     (reset),
        .load      (pc_load),
        .advance   (pc_adv),
        .target    (redirect_pc),
        .pc        (pc),
        .misaligned(misaligned)
    );

    assign imem_addr   = pc;
    assign fetch_fault = fault_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_BOOT;
            id_valid    <= 1'b0;
            id_instr    <= NOP_INSTR;
            id_pc       <= 32'h0;
            id_pc_plus4 <= 32'h4;
            fault_q     <= 1'b0;
        end else begin
            unique case (state)
                ST_BOOT: begin
                    if (redirect_valid && misaligned) begin
                        state   <= ST_FAULT;
                        fault_q <= 1'b1;
                    end else begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (redirect_valid) begin
                        // Flush; decode still takes the old word if ready.
                        id_valid <= 1'b0;
                        if (misaligned) begin
                            state   <= ST_FAULT;
                            fault_q <= 1'b1;
                        end
                    end else if (adv) begin
                        id_valid    <= 1'b1;
                        id_instr    <= imem_rd;
                        id_pc       <= pc;
                        id_pc_plus4 <= pc_inc(pc);
                    end
                end
                ST_FAULT: begin
                    if (id_ready) begin
                        id_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage.
// Checks adapt to FETCH_ALIGN_CHECK_EN where behaviour differs.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_rd;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic        fetch_fault;

    int tests = 0;
    int fails = 0;

    localparam logic [31:0] W0  = 32'h0010_0093;
    localparam logic [31:0] W1  = 32'h0010_0113;
    localparam logic [31:0] NOP = 32'h0000_0013;

    always #5 clk = ~clk;

    // Word 0/1 fixed, everything else is addr ^ A5A5_0000.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return W0;
        if (a == 32'h4) return W1;
        return a ^ 32'hA5A5_0000;
    endfunction

    assign imem_rd = mem_word(imem_addr);

    fetch_stage #(
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_addr     (imem_addr),
        .imem_rd       (imem_rd),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .id_ready      (id_ready),
        .id_valid      (id_valid),
        .id_instr      (id_instr),
        .id_pc         (id_pc),
        .id_pc_plus4   (id_pc_plus4),
        .fetch_fault   (fetch_fault)
    );

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests++;
        if ({id_valid, fetch_fault} !== 2'b00) begin
            fails++;
            $display("FAIL reset_flags got %b want 00", {id_valid, fetch_fault});
        end
        tests++;
        if (imem_addr !== 32'h0 || id_instr !== NOP) begin
            fails++;
            $display("FAIL reset_addr_instr got %h/%h want 0/%h", imem_addr, id_instr, NOP);
        end
        tests++;
        if (id_pc !== 32'h0 || id_pc_plus4 !== 32'h4) begin
            fails++;
            $display("FAIL reset_pc got %h/%h want 0/4", id_pc, id_pc_plus4);
        end
        reset = 1'b0;
    endtask

    task automatic test_straight_line();
        step();
        tests++;
        if (id_valid !== 1'b0 || imem_addr !== 32'h0) begin
            fails++;
            $display("FAIL boot_cycle got v=%b a=%h want v=0 a=0", id_valid, imem_addr);
        end
        step();
        tests++;
        if ({id_valid, id_instr, id_pc, id_pc_plus4, imem_addr} !==
            {1'b1, W0, 32'h0, 32'h4, 32'h4}) begin
            fails++;
            $display("FAIL first_fetch got v=%b i=%h pc=%h p4=%h a=%h", id_valid, id_instr, id_pc, id_pc_plus4, imem_addr);
        end
        step();
        tests++;
        if ({id_valid, id_instr, id_pc, id_pc_plus4, imem_addr} !==
            {1'b1, W1, 32'h4, 32'h8, 32'h8}) begin
            fails++;
            $display("FAIL second_fetch got v=%b i=%h pc=%h p4=%h a=%h", id_valid, id_instr, id_pc, id_pc_plus4, imem_addr);
        end
        step();
        tests++;
        if ({id_instr, id_pc, imem_addr} !== {32'hA5A5_0008, 32'h8, 32'hC}) begin
            fails++;
            $display("FAIL third_fetch got i=%h pc=%h a=%h", id_instr, id_pc, imem_addr);
        end
    endtask

    task automatic test_stall();
        id_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            tests++;
            if ({id_valid, id_instr, id_pc, id_pc_plus4, imem_addr} !==
                {1'b1, 32'hA5A5_0008, 32'h8, 32'hC, 32'hC}) begin
                fails++;
                $display("FAIL stall_hold%0d got v=%b i=%h pc=%h a=%h", k, id_valid, id_instr, id_pc, imem_addr);
            end
        end
        id_ready = 1'b1;
        step();
        tests++;
        if ({id_valid, id_instr, id_pc, imem_addr} !== {1'b1, 32'hA5A5_000C, 32'hC, 32'h10}) begin
            fails++;
            $display("FAIL stall_release got v=%b i=%h pc=%h a=%h", id_valid, id_instr, id_pc, imem_addr);
        end
    endtask

    task automatic test_redirect_stall();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h20;
        id_ready       = 1'b0;
        step();
        redirect_valid = 1'b0;
        tests++;
        if (id_valid !== 1'b0 || imem_addr !== 32'h20) begin
            fails++;
            $display("FAIL redir_flush got v=%b a=%h want v=0 a=20", id_valid, imem_addr);
        end
        step();
        id_ready = 1'b1;
        tests++;
        if ({id_valid, id_instr, id_pc, imem_addr} !== {1'b1, 32'hA5A5_0020, 32'h20, 32'h24}) begin
            fails++;
            $display("FAIL redir_target got v=%b i=%h pc=%h a=%h", id_valid, id_instr, id_pc, imem_addr);
        end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        tests++;
        if (id_valid !== 1'b0 || imem_addr !== 32'hFFFF_FFFC) begin
            fails++;
            $display("FAIL wrap_redir got v=%b a=%h", id_valid, imem_addr);
        end
        step();
        tests++;
        if ({id_valid, id_instr, id_pc, id_pc_plus4, imem_addr, fetch_fault} !==
            {1'b1, 32'h5A5A_FFFC, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0}) begin
            fails++;
            $display("FAIL wrap_top got v=%b i=%h pc=%h p4=%h a=%h f=%b", id_valid, id_instr, id_pc, id_pc_plus4, imem_addr, fetch_fault);
        end
        step();
        tests++;
        if ({id_instr, id_pc, id_pc_plus4, imem_addr} !== {W0, 32'h0, 32'h4, 32'h4}) begin
            fails++;
            $display("FAIL wrap_zero got i=%h pc=%h p4=%h a=%h", id_instr, id_pc, id_pc_plus4, imem_addr);
        end
    endtask

    task automatic test_misaligned();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h22;
        step();
`ifdef FETCH_ALIGN_CHECK_EN
        tests++;
        if ({fetch_fault, id_valid, imem_addr} !== {1'b1, 1'b0, 32'h22}) begin
            fails++;
            $display("FAIL misalign_trap got f=%b v=%b a=%h", fetch_fault, id_valid, imem_addr);
        end
        redirect_pc = 32'h40;
        for (int k = 0; k < 2; k++) begin
            step();
            tests++;
            if ({fetch_fault, id_valid, imem_addr} !== {1'b1, 1'b0, 32'h22}) begin
                fails++;
                $display("FAIL fault_ignore%0d got f=%b v=%b a=%h", k, fetch_fault, id_valid, imem_addr);
            end
        end
        redirect_valid = 1'b0;
`else
        redirect_valid = 1'b0;
        tests++;
        if ({fetch_fault, id_valid, imem_addr} !== {1'b0, 1'b0, 32'h20}) begin
            fails++;
            $display("FAIL misalign_mask got f=%b v=%b a=%h", fetch_fault, id_valid, imem_addr);
        end
        step();
        tests++;
        if ({id_valid, id_pc, imem_addr, fetch_fault} !== {1'b1, 32'h20, 32'h24, 1'b0}) begin
            fails++;
            $display("FAIL misalign_resume got v=%b pc=%h a=%h f=%b", id_valid, id_pc, imem_addr, fetch_fault);
        end
`endif
    endtask

    task automatic test_async_reset();
        id_ready = 1'b0;
        step();
        step();
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        tests++;
        if ({id_valid, imem_addr, id_instr, id_pc, fetch_fault} !==
            {1'b0, 32'h0, NOP, 32'h0, 1'b0}) begin
            fails++;
            $display("FAIL async_reset got v=%b a=%h i=%h pc=%h f=%b", id_valid, imem_addr, id_instr, id_pc, fetch_fault);
        end
        @(negedge clk);
        reset    = 1'b0;
        id_ready = 1'b1;
        step();
        tests++;
        if (id_valid !== 1'b0) begin
            fails++;
            $display("FAIL reboot_boot got v=%b want 0", id_valid);
        end
        step();
        tests++;
        if ({id_valid, id_instr, id_pc, imem_addr} !== {1'b1, W0, 32'h0, 32'h4}) begin
            fails++;
            $display("FAIL reboot_fetch got v=%b i=%h pc=%h a=%h", id_valid, id_instr, id_pc, imem_addr);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_ready       = 1'b1;
        test_reset();
        test_straight_line();
        test_stall();
        test_redirect_stall();
        test_wrap();
        test_misaligned();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
